// File: rtl/miniproc_pkg.sv
// Shared constants for the mini processor pipeline: register file geometry, datapath
// width and the opcode encodings agreed between decode, operand fetch and execute.
package miniproc_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OpNop = 6'h00;
    localparam logic [OPW-1:0] OpAdd = 6'h01;
    localparam logic [OPW-1:0] OpSub = 6'h02;
    localparam logic [OPW-1:0] OpAnd = 6'h03;
    localparam logic [OPW-1:0] OpOr  = 6'h04;
    localparam logic [OPW-1:0] OpXor = 6'h05;

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a writing
// instruction issues and cleared by writeback. A same-cycle set beats the clear.
module of_scoreboard #(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_i,
    input  logic [AW-1:0]   set_addr_i,
    input  logic            clr_i,
    input  logic [AW-1:0]   clr_addr_i,
    output logic [NREG-1:0] pend_o
);

    logic [NREG-1:0] pend_d, pend_q;

    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d[clr_addr_i] = 1'b0;
        if (set_i) pend_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the 2R1W regfile: reads both operands, bypasses same-cycle
// writeback, stalls RAW/WAW hazards via the scoreboard, and registers the result for execute.
module operand_fetch
    import miniproc_pkg::*;
#(
    parameter int unsigned NREG = miniproc_pkg::NREG,
    parameter int unsigned AW   = miniproc_pkg::AW,
    parameter int unsigned DW   = miniproc_pkg::DW,
    parameter int unsigned OPW  = miniproc_pkg::OPW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [AW-1:0]  in_rs1,
    input  logic [AW-1:0]  in_rs2,
    input  logic [AW-1:0]  in_rd,
    input  logic           in_wr,
    output logic [AW-1:0]  rf_add1,
    output logic [AW-1:0]  rf_add2,
    input  logic [DW-1:0]  rf_data1,
    input  logic [DW-1:0]  rf_data2,
    input  logic           wb_wen_n,
    input  logic [AW-1:0]  wb_addw,
    input  logic [DW-1:0]  wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_op,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [AW-1:0]  out_rd,
    output logic           out_wr
);

    logic [NREG-1:0] pend;
    logic            wb_en, hit1, hit2, hitd, hazard, accept;

    logic           valid_d, valid_q;
    logic [OPW-1:0] op_d, op_q;
    logic [DW-1:0]  a_d, a_q, b_d, b_q;
    logic [AW-1:0]  rd_d, rd_q;
    logic           wr_d, wr_q;

    assign rf_add1 = in_rs1;
    assign rf_add2 = in_rs2;

    assign wb_en = !wb_wen_n;
    assign hit1  = wb_en && (wb_addw == in_rs1);
    assign hit2  = wb_en && (wb_addw == in_rs2);
    assign hitd  = wb_en && (wb_addw == in_rd);

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    assign hazard = in_valid && ((pend[in_rs1] && !hit1) || (pend[in_rs2] && !hit2) ||
                                 (in_wr && pend[in_rd] && !hitd));

    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    of_scoreboard #(
        .NREG(NREG),
        .AW  (AW)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_i     (reset),
        .set_i     (accept && in_wr),
        .set_addr_i(in_rd),
        .clr_i     (wb_en),
        .clr_addr_i(wb_addw),
        .pend_o    (pend)
    );

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (accept) begin
            valid_d = 1'b1;
            op_d    = in_op;
            a_d     = hit1 ? wb_data : rf_data1;
            b_d     = hit2 ? wb_data : rf_data2;
            rd_d    = in_rd;
            wr_d    = in_wr;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_rd    = rd_q;
    assign out_wr    = wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed scenarios followed by random traffic, checked against a behavioural model of
// the regfile, pending-register set and output slot kept in the bench.
module tb_operand_fetch;
    import miniproc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, in_wr, wb_wen_n, out_valid, out_ready, out_wr;
    logic [OPW-1:0] in_op, out_op;
    logic [AW-1:0]  in_rs1, in_rs2, in_rd, rf_add1, rf_add2, wb_addw, out_rd;
    logic [DW-1:0]  rf_data1, rf_data2, wb_data, out_a, out_b;

    // Bench-side register file with combinational read.
    logic [DW-1:0] rf [NREG];
    assign rf_data1 = rf[rf_add1];
    assign rf_data2 = rf[rf_add2];

    operand_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_rd    (in_rd),
        .in_wr    (in_wr),
        .rf_add1  (rf_add1),
        .rf_add2  (rf_add2),
        .rf_data1 (rf_data1),
        .rf_data2 (rf_data2),
        .wb_wen_n (wb_wen_n),
        .wb_addw  (wb_addw),
        .wb_data  (wb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_op   (out_op),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_rd   (out_rd),
        .out_wr   (out_wr)
    );

    // Reference model: set of registers with an outstanding write, plus the single output slot.
    bit             m_pend [NREG];
    bit             m_ov;
    logic [OPW-1:0] m_op;
    logic [DW-1:0]  m_a, m_b;
    logic [AW-1:0]  m_rd;
    bit             m_wr;
    bit             m_stall;
    int             acc_cnt = 0;
    int             n_assert = 0;
    int             n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hits(input logic [AW-1:0] r);
        return !wb_wen_n && (wb_addw == r);
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_ov = 0; m_op = '0; m_a = '0; m_b = '0; m_rd = '0; m_wr = 0; m_stall = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, " out_valid"}, out_valid, m_ov);
        chk({tag, " out_op"}, out_op, m_op);
        chk({tag, " out_a"}, out_a, m_a);
        chk({tag, " out_b"}, out_b, m_b);
        chk({tag, " out_rd"}, out_rd, m_rd);
        chk({tag, " out_wr"}, out_wr, m_wr);
    endtask

    // One clock: check handshake before the edge, advance the model, check outputs after.
    task automatic cycle(input string tag);
        bit            blocked, rdy, acc;
        logic [DW-1:0] va, vb;
        #1;
        blocked = in_valid && ((m_pend[in_rs1] && !wb_hits(in_rs1)) ||
                               (m_pend[in_rs2] && !wb_hits(in_rs2)) ||
                               (in_wr && m_pend[in_rd] && !wb_hits(in_rd)));
        rdy = (!m_ov || out_ready) && !blocked;
        chk({tag, " in_ready"}, in_ready, rdy);
        chk({tag, " rf_add"}, {rf_add1, rf_add2}, {in_rs1, in_rs2});
        acc = in_valid && rdy;
        va = wb_hits(in_rs1) ? wb_data : rf[in_rs1];
        vb = wb_hits(in_rs2) ? wb_data : rf[in_rs2];
        m_stall = in_valid && !rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            acc_cnt++;
            m_ov = 1; m_op = in_op; m_a = va; m_b = vb; m_rd = in_rd; m_wr = in_wr;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (!wb_wen_n) begin
            m_pend[wb_addw] = 1'b0;
            rf[wb_addw] = wb_data;
        end
        if (acc && in_wr) m_pend[in_rd] = 1'b1;
        chk_outputs(tag);
    endtask

    task automatic issue(input logic [OPW-1:0] op, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic wr);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr = wr;
    endtask

    initial begin
        logic [DW-1:0] held_a;
        int            base;
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        rf[3] = 32'd5;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_wr = 1'b0; wb_wen_n = 1'b1; wb_addw = '0; wb_data = '0; out_ready = 1'b1;
        model_reset();
        #2;
        chk_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Plain read of r3 into both operands.
        issue(OpAdd, 4'd3, 4'd3, 4'd0, 1'b0);
        cycle("t2");
        chk("t2 a", out_a, 32'd5);
        chk("t2 b", out_b, 32'd5);

        // RAW on r4 resolved by the writeback bypass.
        issue(OpSub, 4'd0, 4'd1, 4'd4, 1'b1);
        cycle("t3 prod");
        issue(OpAnd, 4'd4, 4'd1, 4'd7, 1'b0);
        cycle("t3 stall0");
        cycle("t3 stall1");
        wb_wen_n = 1'b0; wb_addw = 4'd4; wb_data = 32'd9;
        cycle("t3 bypass");
        chk("t3 a", out_a, 32'd9);
        wb_wen_n = 1'b1;

        // Backpressure holds the output slot.
        out_ready = 1'b0;
        issue(OpOr, 4'd5, 4'd6, 4'd8, 1'b0);
        held_a = m_a;
        for (int i = 0; i < 3; i++) cycle("t4 hold");
        chk("t4 held a", out_a, held_a);
        out_ready = 1'b1;
        cycle("t4 release");
        in_valid = 1'b0;
        cycle("t4 drain");
        chk("t4 drained", out_valid, 1'b0);

        // Independent stream: one accept per cycle.
        base = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            issue(OpXor, 4'(8 + i), 4'(15 - i), 4'(i), 1'b0);
            cycle("t6 stream");
        end
        chk("t6 accepts", acc_cnt - base, 8);
        in_valid = 1'b0;

        // WAW on r2; writeback and new producer in the same cycle keep r2 pending.
        issue(OpAdd, 4'd0, 4'd1, 4'd2, 1'b1);
        cycle("t5 first");
        cycle("t5 waw stall");
        wb_wen_n = 1'b0; wb_addw = 4'd2; wb_data = 32'h0bad_cafe;
        cycle("t5 set+clr");
        wb_wen_n = 1'b1;
        out_ready = 1'b0;
        issue(OpAdd, 4'd2, 4'd0, 4'd9, 1'b0);
        #1 chk("t5 still pending", in_ready, 1'b0);
        cycle("t5 raw stall");

        // Asynchronous reset mid-stream with a pending register and a held result.
        reset = 1'b1;
        #1;
        model_reset();
        chk("t1 out_valid", out_valid, 1'b0);
        chk("t1 pend cleared", in_ready, 1'b1);
        chk_outputs("t1 async");
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;

        // Random traffic; decode holds a stalled instruction stable.
        for (int n = 0; n < 400; n++) begin
            if (!m_stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op = 6'($urandom_range(0, 5));
                in_rs1 = 4'($urandom); in_rs2 = 4'($urandom);
                in_rd = 4'($urandom); in_wr = 1'($urandom);
            end
            wb_wen_n = ($urandom_range(0, 2) != 0);
            wb_addw = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < NREG; k++) begin
                    if (m_pend[4'(wb_addw + 4'(k))]) begin
                        wb_addw = 4'(wb_addw + 4'(k));
                        break;
                    end
                end
            end
            wb_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
